// File: rtl/dpram_arb.sv
// Round-robin arbiter for the shared write (byte) and read (word) ports of a dual-port RAM.
// Reads that would hit the word being written in the same cycle are stalled one cycle.
module dpram_arb #(
   parameter int unsigned BA_W = 6,
   parameter int unsigned BD_W = 8,
   parameter int unsigned WA_W = 5,
   parameter int unsigned WD_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            w0_req,
   input  logic [BA_W-1:0] w0_addr,
   input  logic [BD_W-1:0] w0_data,
   output logic            w0_gnt,
   input  logic            w1_req,
   input  logic [BA_W-1:0] w1_addr,
   input  logic [BD_W-1:0] w1_data,
   output logic            w1_gnt,
   input  logic            r0_req,
   input  logic [WA_W-1:0] r0_addr,
   output logic            r0_gnt,
   input  logic            r1_req,
   input  logic [WA_W-1:0] r1_addr,
   output logic            r1_gnt,
   output logic            rd_valid,
   output logic            rd_id,
   output logic [WD_W-1:0] rd_data,
   output logic            ram_we,
   output logic [BA_W-1:0] ram_wa,
   output logic [BD_W-1:0] ram_wd,
   output logic [WA_W-1:0] ram_ra,
   input  logic [WD_W-1:0] ram_rd
);

   logic            w_ptr_q, w_ptr_d;
   logic            r_ptr_q, r_ptr_d;
   logic [BA_W-1:0] wa_q, wa_d;
   logic [BD_W-1:0] wd_q, wd_d;
   logic [WA_W-1:0] ra_q, ra_d;
   logic            rd_valid_q, rd_valid_d;
   logic            rd_id_q, rd_id_d;

   logic            w_gnt0, w_gnt1, w_any;
   logic            r_gnt0, r_gnt1, r_any;
   logic            r0_elig, r1_elig;
   logic [BA_W-1:0] w_addr_sel;
   logic [BD_W-1:0] w_data_sel;
   logic [WA_W-1:0] r_addr_sel;
   logic [WA_W-1:0] haz_word;

   // Write side: pointer value names the favoured writer when both request.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!reset) begin
         if (w0_req && (!w1_req || !w_ptr_q)) begin
            w_gnt0 = 1'b1;
         end else if (w1_req) begin
            w_gnt1 = 1'b1;
         end
      end
      w_any      = w_gnt0 | w_gnt1;
      w_addr_sel = w_gnt1 ? w1_addr : w0_addr;
      w_data_sel = w_gnt1 ? w1_data : w0_data;
      haz_word   = WA_W'(w_addr_sel >> 1);
   end

   // Read side: a reader targeting the word being written this cycle is not eligible.
   always_comb begin
      r0_elig = r0_req && !(w_any && (r0_addr == haz_word));
      r1_elig = r1_req && !(w_any && (r1_addr == haz_word));
      r_gnt0  = 1'b0;
      r_gnt1  = 1'b0;
      if (!reset) begin
         if (r0_elig && (!r1_elig || !r_ptr_q)) begin
            r_gnt0 = 1'b1;
         end else if (r1_elig) begin
            r_gnt1 = 1'b1;
         end
      end
      r_any      = r_gnt0 | r_gnt1;
      r_addr_sel = r_gnt1 ? r1_addr : r0_addr;
   end

   // Pointer always lands on the loser, so a stalled reader keeps priority.
   always_comb begin
      w_ptr_d    = w_any ? w_gnt0 : w_ptr_q;
      r_ptr_d    = r_any ? r_gnt0 : r_ptr_q;
      wa_d       = w_any ? w_addr_sel : wa_q;
      wd_d       = w_any ? w_data_sel : wd_q;
      ra_d       = r_any ? r_addr_sel : ra_q;
      rd_valid_d = r_any;
      rd_id_d    = r_gnt1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_ptr_q    <= 1'b0;
         r_ptr_q    <= 1'b0;
         wa_q       <= '0;
         wd_q       <= '0;
         ra_q       <= '0;
         rd_valid_q <= 1'b0;
         rd_id_q    <= 1'b0;
      end else begin
         w_ptr_q    <= w_ptr_d;
         r_ptr_q    <= r_ptr_d;
         wa_q       <= wa_d;
         wd_q       <= wd_d;
         ra_q       <= ra_d;
         rd_valid_q <= rd_valid_d;
         rd_id_q    <= rd_id_d;
      end
   end

   // Outputs are forced quiet while reset is held, including a return already in flight.
   always_comb begin
      w0_gnt   = w_gnt0;
      w1_gnt   = w_gnt1;
      r0_gnt   = r_gnt0;
      r1_gnt   = r_gnt1;
      ram_we   = w_any;
      ram_wa   = reset ? '0 : wa_d;
      ram_wd   = reset ? '0 : wd_d;
      ram_ra   = reset ? '0 : ra_d;
      rd_valid = rd_valid_q & ~reset;
      rd_id    = rd_id_q & ~reset;
      rd_data  = ram_rd;
   end

endmodule
